// File: rtl/rand_delay_timer.sv
// Random-delay timer. It captures a pseudo-random value (plus a fixed offset)
// when triggered, then counts that many timebase ticks and emits a one-cycle
// time_out pulse. The upstream generator is frozen while a delay runs so the
// captured value stays observable on rnd.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for trigger; generator free-running
// COUNT | down-counting remaining on each tick; abort returns to IDLE
// FIRE  | single cycle with time_out high, then back to IDLE
module rand_delay_timer #(
    parameter int WIDTH  = 4,
    parameter int OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rnd,
    output logic             lfsr_en,
    input  logic             trigger,
    input  logic             abort,
    input  logic             tick,
    output logic             busy,
    output logic             time_out,
    output logic [WIDTH:0]   delay_val,
    output logic [WIDTH:0]   remaining
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } state_t;

    localparam logic [WIDTH:0] OFF_W = (WIDTH+1)'(OFFSET);
    localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);

    state_t         state;
    state_t         state_nxt;
    logic [WIDTH:0] rem_nxt;
    logic [WIDTH:0] dval_nxt;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] cap_val;
    // Low during reset and for the first cycle after it, so the generator
    // enable only comes back on the first clock edge after release.
    logic           armed;

    // One extra bit keeps rnd + OFFSET from wrapping; a zero delay becomes 1.
    assign sum     = {1'b0, rnd} + OFF_W;
    assign cap_val = (sum == '0) ? ONE : sum;

    // Next-state and counter/capture update.
    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        dval_nxt  = delay_val;
        case (state)
            IDLE: begin
                if (trigger && !abort) begin
                    rem_nxt   = cap_val;
                    dval_nxt  = cap_val;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                // abort wins over the final tick, so no pulse is issued
                if (abort) begin
                    rem_nxt   = '0;
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (remaining == ONE) begin
                        rem_nxt   = '0;
                        state_nxt = FIRE;
                    end else begin
                        rem_nxt = remaining - ONE;
                    end
                end
            end
            FIRE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                rem_nxt   = '0;
            end
        endcase
    end

    // State, counter and captured-delay registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            delay_val <= '0;
            armed     <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
            delay_val <= dval_nxt;
            armed     <= 1'b1;
        end
    end

    // Outputs decode registered state only; no input reaches an output.
    always_comb begin
        busy     = (state != IDLE);
        time_out = (state == FIRE);
        lfsr_en  = armed && (state == IDLE);
    end

endmodule

// File: tb/tb_rand_delay_timer.sv
// Bench for rand_delay_timer. Two instances share all inputs: one with
// OFFSET=0 and one with OFFSET=2. Expected behaviour comes from the delay
// rules: d = max(1, rnd + OFFSET), time_out on the sample right after the
// d-th tick following capture, unless abort arrives first.
module tb_rand_delay_timer;

    logic       clk;
    logic       rst_n;
    logic [3:0] rnd;
    logic       trigger;
    logic       abort;
    logic       tick;
    logic [1:0] lfsr_o;
    logic [1:0] busy_o;
    logic [1:0] to_o;
    logic [4:0] dval_o [2];
    logic [4:0] rem_o  [2];

    int checks = 0;
    int errors = 0;

    rand_delay_timer #(.WIDTH(4), .OFFSET(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rnd(rnd), .lfsr_en(lfsr_o[0]),
        .trigger(trigger), .abort(abort), .tick(tick), .busy(busy_o[0]),
        .time_out(to_o[0]), .delay_val(dval_o[0]), .remaining(rem_o[0])
    );

    rand_delay_timer #(.WIDTH(4), .OFFSET(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .rnd(rnd), .lfsr_en(lfsr_o[1]),
        .trigger(trigger), .abort(abort), .tick(tick), .busy(busy_o[1]),
        .time_out(to_o[1]), .delay_val(dval_o[1]), .remaining(rem_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        trigger = 0; abort = 0; tick = 0;
        #2 rst_n = 1'b0;
        #7 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rnd = 4'd3; trigger = 1; abort = 0; tick = 1;
        #12;
        for (int i = 0; i < 2; i++) begin
            checks++; if (busy_o[i] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got %b exp 0", i, busy_o[i]); end
            checks++; if (to_o[i] !== 1'b0) begin errors++; $display("FAIL reset_to dut%0d got %b exp 0", i, to_o[i]); end
            checks++; if (lfsr_o[i] !== 1'b0) begin errors++; $display("FAIL reset_lfsr dut%0d got %b exp 0", i, lfsr_o[i]); end
            checks++; if (rem_o[i] !== 5'd0) begin errors++; $display("FAIL reset_rem dut%0d got %0d exp 0", i, rem_o[i]); end
            checks++; if (dval_o[i] !== 5'd0) begin errors++; $display("FAIL reset_dval dut%0d got %0d exp 0", i, dval_o[i]); end
        end
        trigger = 0; tick = 0;
        @(posedge clk); #3 rst_n = 1'b1; #1;
        checks++; if (lfsr_o !== 2'b00) begin errors++; $display("FAIL rel_lfsr_pre got %b exp 00", lfsr_o); end
        @(posedge clk); #1;
        checks++; if (lfsr_o !== 2'b11) begin errors++; $display("FAIL rel_lfsr_post got %b exp 11", lfsr_o); end
        checks++; if (busy_o !== 2'b00) begin errors++; $display("FAIL rel_busy got %b exp 00", busy_o); end
    endtask

    // One delay run. abort_k > 0: abort together with the abort_k-th tick.
    // abort_k < 0: abort on the non-tick cycle after the |abort_k|-th tick.
    // retrig: pulse trigger with a different rnd early in the count.
    task automatic run_delay(input string nm, input logic [3:0] r, input int period,
                             input int abort_k, input bit retrig);
        int d [2];
        int ph [2];   // 0 counting, 1 pulse visible, 2 finished, 3 aborted
        int k;
        int gap;
        bit t;
        bit a;
        bit ab_done;
        logic       exp_busy;
        logic       exp_to;
        logic [4:0] exp_rem;
        d[0] = (r == 0) ? 1 : int'(r);
        d[1] = int'(r) + 2;
        rnd = r; trigger = 1; tick = 1; abort = 0;
        @(posedge clk); #1;
        trigger = 0; tick = 0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (dval_o[i] !== 5'(d[i])) begin errors++; $display("FAIL %s_cap_dval dut%0d got %0d exp %0d", nm, i, dval_o[i], d[i]); end
            checks++; if (rem_o[i] !== 5'(d[i])) begin errors++; $display("FAIL %s_cap_rem dut%0d got %0d exp %0d", nm, i, rem_o[i], d[i]); end
            checks++; if (busy_o[i] !== 1'b1 || lfsr_o[i] !== 1'b0) begin errors++; $display("FAIL %s_cap_busy dut%0d got busy %b lfsr %b exp 1 0", nm, i, busy_o[i], lfsr_o[i]); end
        end
        k = 0; gap = 0; ab_done = 0;
        ph[0] = 0; ph[1] = 0;
        for (int cyc = 0; cyc < 400 && !(ph[0] >= 2 && ph[1] >= 2); cyc++) begin
            gap++;
            t = (gap == period);
            if (t) gap = 0;
            a = (abort_k > 0 && t && k + 1 == abort_k) ||
                (abort_k < 0 && !t && k == -abort_k && !ab_done);
            if (a) ab_done = 1;
            tick = t; abort = a;
            trigger = retrig && (cyc == 1);
            if (retrig && cyc == 1) rnd = ~r;
            @(posedge clk); #1;
            tick = 0; abort = 0; trigger = 0;
            if (t && !a) k++;
            for (int i = 0; i < 2; i++) begin
                if (ph[i] == 1) ph[i] = 2;
                else if (ph[i] == 0) begin
                    if (a) ph[i] = 3;
                    else if (k == d[i]) ph[i] = 1;
                end
                exp_busy = (ph[i] <= 1);
                exp_to   = (ph[i] == 1);
                exp_rem  = (ph[i] == 0) ? 5'(d[i] - k) : 5'd0;
                checks++; if (busy_o[i] !== exp_busy) begin errors++; $display("FAIL %s_busy dut%0d cyc %0d got %b exp %b", nm, i, cyc, busy_o[i], exp_busy); end
                checks++; if (to_o[i] !== exp_to) begin errors++; $display("FAIL %s_time_out dut%0d cyc %0d got %b exp %b", nm, i, cyc, to_o[i], exp_to); end
                checks++; if (rem_o[i] !== exp_rem) begin errors++; $display("FAIL %s_rem dut%0d cyc %0d got %0d exp %0d", nm, i, cyc, rem_o[i], exp_rem); end
                checks++; if (lfsr_o[i] !== !exp_busy) begin errors++; $display("FAIL %s_lfsr dut%0d cyc %0d got %b exp %b", nm, i, cyc, lfsr_o[i], !exp_busy); end
                checks++; if (dval_o[i] !== 5'(d[i])) begin errors++; $display("FAIL %s_dval dut%0d cyc %0d got %0d exp %0d", nm, i, cyc, dval_o[i], d[i]); end
            end
        end
        checks++;
        if (!(ph[0] >= 2 && ph[1] >= 2)) begin
            errors++; $display("FAIL %s_timeout phases %0d %0d exp finished", nm, ph[0], ph[1]);
        end
    endtask

    task automatic test_back_to_back();
        rnd = 4'd2; trigger = 1; tick = 1; abort = 0;
        @(posedge clk); #1;
        checks++; if (dval_o[0] !== 5'd2 || rem_o[0] !== 5'd2) begin errors++; $display("FAIL b2b_cap got dval %0d rem %0d exp 2 2", dval_o[0], rem_o[0]); end
        @(posedge clk); #1;
        checks++; if (rem_o[0] !== 5'd1) begin errors++; $display("FAIL b2b_rem got %0d exp 1", rem_o[0]); end
        @(posedge clk); #1;
        checks++; if (to_o[0] !== 1'b1) begin errors++; $display("FAIL b2b_fire got %b exp 1", to_o[0]); end
        rnd = 4'd7;
        @(posedge clk); #1;
        checks++; if (busy_o[0] !== 1'b0 || to_o[0] !== 1'b0 || lfsr_o[0] !== 1'b1) begin errors++; $display("FAIL b2b_idle got busy %b to %b lfsr %b exp 0 0 1", busy_o[0], to_o[0], lfsr_o[0]); end
        @(posedge clk); #1;
        checks++; if (busy_o[0] !== 1'b1 || dval_o[0] !== 5'd7 || rem_o[0] !== 5'd7) begin errors++; $display("FAIL b2b_recap got busy %b dval %0d rem %0d exp 1 7 7", busy_o[0], dval_o[0], rem_o[0]); end
        trigger = 0; tick = 0;
        do_reset();
    endtask

    task automatic test_async_reset();
        rnd = 4'd9; trigger = 1; tick = 0; abort = 0;
        @(posedge clk); #1;
        trigger = 0;
        for (int i = 0; i < 4; i++) begin
            tick = (i % 2 == 0);
            @(posedge clk); #1;
        end
        tick = 0;
        checks++; if (busy_o !== 2'b11 || rem_o[0] !== 5'd7) begin errors++; $display("FAIL arst_pre got busy %b rem %0d exp 11 7", busy_o, rem_o[0]); end
        #2 rst_n = 1'b0; #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (busy_o[i] !== 1'b0 || rem_o[i] !== 5'd0 || lfsr_o[i] !== 1'b0 || to_o[i] !== 1'b0) begin
                errors++; $display("FAIL arst_now dut%0d got busy %b rem %0d lfsr %b to %b exp 0 0 0 0", i, busy_o[i], rem_o[i], lfsr_o[i], to_o[i]);
            end
            checks++; if (dval_o[i] !== 5'd0) begin errors++; $display("FAIL arst_dval dut%0d got %0d exp 0", i, dval_o[i]); end
        end
        @(posedge clk); #1;
        checks++; if (lfsr_o !== 2'b00 || busy_o !== 2'b00) begin errors++; $display("FAIL arst_hold got lfsr %b busy %b exp 00 00", lfsr_o, busy_o); end
        #2 rst_n = 1'b1; #1;
        checks++; if (lfsr_o !== 2'b00) begin errors++; $display("FAIL arst_rel_pre got %b exp 00", lfsr_o); end
        @(posedge clk); #1;
        checks++; if (lfsr_o !== 2'b11 || to_o !== 2'b00) begin errors++; $display("FAIL arst_rel_post got lfsr %b to %b exp 11 00", lfsr_o, to_o); end
    endtask

    task automatic test_abort_with_trigger();
        rnd = 4'd4; trigger = 1; abort = 1; tick = 0;
        @(posedge clk); #1;
        trigger = 0; abort = 0;
        checks++; if (busy_o !== 2'b00 || dval_o[0] !== 5'd0) begin errors++; $display("FAIL trig_abort got busy %b dval %0d exp 00 0", busy_o, dval_o[0]); end
    endtask

    task automatic test_random();
        logic [3:0] r;
        int p;
        int ab;
        for (int n = 0; n < 8; n++) begin
            r  = 4'($urandom_range(15, 0));
            p  = int'($urandom_range(4, 1));
            ab = ($urandom_range(2, 0) == 0) ? int'($urandom_range(18, 1)) : 0;
            run_delay("rand", r, p, ab, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_abort_with_trigger();
        run_delay("basic", 4'd5, 4, 0, 1'b0);
        run_delay("zero", 4'd0, 3, 0, 1'b0);
        run_delay("max", 4'd15, 2, 0, 1'b0);
        run_delay("abort3", 4'd9, 4, -3, 1'b0);
        run_delay("abort_final", 4'd9, 3, 9, 1'b0);
        run_delay("retrig", 4'd6, 3, 0, 1'b1);
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rand_delay_timer.md
RAND_DELAY_TIMER -- requirements
Module: rand_delay_timer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the width of the random input in bits.
REQ-002 The module SHALL have parameter OFFSET, default 0, a constant number of ticks added to every captured random value.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port rnd, input, WIDTH bits: the pseudo-random value from the upstream shift-register generator.
REQ-006 The module SHALL have port lfsr_en, output, 1 bit: enable to the upstream generator.
REQ-007 The module SHALL have port trigger, input, 1 bit: a level sampled each clk that starts a delay.
REQ-008 The module SHALL have port abort, input, 1 bit: cancels a running delay.
REQ-009 The module SHALL have port tick, input, 1 bit: a one-cycle timebase strobe, for example 1 ms.
REQ-010 The module SHALL have port busy, output, 1 bit: high while a delay is in progress.
REQ-011 The module SHALL have port time_out, output, 1 bit: a one-cycle pulse when the delay expires.
REQ-012 The module SHALL have port delay_val, output, WIDTH+1 bits: the delay loaded at the last capture, in ticks.
REQ-013 The module SHALL have port remaining, output, WIDTH+1 bits: the live value of the down-counter.

Function
REQ-014 The block SHALL implement a three-state machine with states IDLE, COUNT and FIRE.
REQ-015 In IDLE, lfsr_en SHALL be 1 on every cycle, so that the generator advances continuously and the captured value depends on trigger timing.
REQ-016 In IDLE, when trigger=1 and abort=0, the block SHALL capture d = rnd + OFFSET, computed WIDTH+1 bits wide without overflow.
REQ-017 If d equals 0, the block SHALL substitute 1, so that the minimum delay is 1 tick.
REQ-018 On capture, the block SHALL load d into both remaining and delay_val, and the next state SHALL be COUNT.
REQ-019 lfsr_en SHALL be 0 in COUNT and in FIRE, so that the generator holds its value while a delay runs.
REQ-020 busy SHALL be 1 in COUNT and in FIRE, and 0 in IDLE.
REQ-021 In COUNT, on a cycle with tick=1, remaining SHALL decrement by 1.
REQ-022 In COUNT, on a cycle with tick=1 and remaining=1, remaining SHALL become 0 and the next state SHALL be FIRE.
REQ-023 On cycles with tick=0, remaining SHALL hold.
REQ-024 A tick in the same cycle as capture SHALL NOT be counted; counting SHALL begin on the cycle after entry to COUNT.
REQ-025 time_out SHALL be 1 for exactly the one cycle spent in FIRE, and FIRE SHALL return unconditionally to IDLE.
REQ-026 time_out SHALL be asserted exactly d ticks after capture, on the cycle following the d-th counted tick.
REQ-027 abort=1 in COUNT SHALL force the next state to IDLE, clear remaining to 0, leave delay_val unchanged and produce no time_out pulse.
REQ-028 abort=1 in the same cycle as the final tick SHALL take priority: the next state SHALL be IDLE and no time_out pulse SHALL occur.
REQ-029 abort SHALL have no effect in FIRE, so a pulse already issued completes.
REQ-030 trigger=1 in COUNT or in FIRE SHALL be ignored.
REQ-031 A trigger held high through the FIRE-to-IDLE return SHALL start a new capture on the first IDLE cycle, so back-to-back delays are permitted.
REQ-032 trigger=1 together with abort=1 in IDLE SHALL NOT start a delay.
REQ-033 delay_val SHALL change only on capture or on reset.
REQ-034 All outputs SHALL be driven from registered state or from decoding of the state register only, with no combinational path from any input to any output.

Reset
REQ-035 While rst_n=0, the block SHALL be held in IDLE, immediately and independently of clk.
REQ-036 While rst_n=0, outputs SHALL be remaining=0, delay_val=0, busy=0 and time_out=0.
REQ-037 While rst_n=0, lfsr_en SHALL be 0.
REQ-038 Reset asserted during COUNT or FIRE SHALL abandon the delay with no time_out pulse.
REQ-039 After the first rising clk edge following rst_n deassertion, lfsr_en SHALL return to 1.

Verification
REQ-040 Basic delay: WIDTH=4, OFFSET=0, rnd=4'd5, trigger pulsed one cycle, tick every 4 clk -> delay_val=5, busy=1, and time_out pulses once, one cycle after the 5th tick after capture, then busy=0.
REQ-041 Zero substitution: rnd=0, OFFSET=0, trigger -> delay_val=1, and time_out follows the first subsequent tick.
REQ-042 Maximum width: rnd=4'd15, OFFSET=2 -> delay_val=17, with no overflow in the 5-bit counter, and time_out after 17 ticks.
REQ-043 Abort: rnd=9, abort asserted after 3 ticks -> remaining=0, busy=0, no time_out, delay_val stays 9; and a separate run with abort on the same cycle as the 9th tick -> no time_out.
REQ-044 Ignored retrigger: a retrigger during COUNT -> remaining is unaffected; and trigger held high through FIRE -> a new capture on the next IDLE cycle.
REQ-045 Async reset mid-count: rst_n pulled low between clk edges during COUNT -> busy=0, remaining=0 and lfsr_en=0 immediately; after release, lfsr_en=1 from the next edge.
